// File: rtl/uart_ch340_rx_core.sv
// UART receiver for the CH340 TX line: 2-FF synchroniser, 3-sample majority vote per bit,
// optional parity, and a valid/ready holding register with framing/parity/overrun pulses.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | validating the start bit (majority 1 = glitch)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | checking the parity bit
// STOP   | deciding the stop bit at mid-bit
// BREAK  | line held low after a framing error, wait for high
module uart_ch340_rx_core #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int PARITY   = 0
) (
  input  logic       sclk,
  input  logic       nrst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SMP_A    = CW'(HALF - 1);
  localparam logic [CW-1:0] SMP_B    = CW'(HALF);
  localparam logic [CW-1:0] SMP_C    = CW'(HALF + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s, rx_s_d1;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          smp_a, smp_b;
  logic          par_bad;
  logic          fall, maj, decide, bit_end, par_exp;
  logic          stop_ok, stop_perr, stop_ferr;

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d1 <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d1 <= rx_s;
    end
  end

  assign fall    = rx_s_d1 & ~rx_s;
  assign maj     = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign decide  = (cnt == SMP_C);
  assign bit_end = (cnt == CNT_LAST);
  // Expected parity bit: even = XOR of data, odd = its inverse.
  assign par_exp = (^shreg) ^ (PARITY == 1);

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fall) state_nxt = S_START;
      S_START: begin
        if (decide && maj) state_nxt = S_IDLE;
        else if (bit_end)  state_nxt = S_DATA;
      end
      S_DATA:   if (bit_end && bit_idx == 3'd7) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (decide) state_nxt = maj ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    stop_ok   = (state == S_STOP) && decide && maj && !par_bad;
    stop_perr = (state == S_STOP) && decide && maj && par_bad;
    stop_ferr = (state == S_STOP) && decide && !maj;
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      cnt     <= '0;
      smp_a   <= 1'b1;
      smp_b   <= 1'b1;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      par_bad <= 1'b0;
    end else begin
      if (state == S_IDLE || state == S_BREAK || bit_end) cnt <= '0;
      else                                                cnt <= cnt + 1'b1;
      if (cnt == SMP_A) smp_a <= rx_s;
      if (cnt == SMP_B) smp_b <= rx_s;
      if (state == S_START)                bit_idx <= 3'd0;
      else if (state == S_DATA && bit_end) bit_idx <= bit_idx + 3'd1;
      if (state == S_DATA && decide) shreg[bit_idx] <= maj;
      if (state == S_START)                  par_bad <= 1'b0;
      else if (state == S_PARITY && decide) par_bad <= maj ^ par_exp;
    end
  end

  // A byte arriving while the previous one is still unclaimed is dropped, not overwritten.
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= stop_ferr;
      parity_err <= stop_perr;
      overrun    <= stop_ok && rx_valid && !rx_ready;
      if (stop_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_ch340_rx_core.sv
// Scoreboard bench for uart_ch340_rx_core: one receiver without parity, one with even parity.
module tb_uart_ch340_rx_core;

  localparam int CPB = 434;
  localparam logic [1:0] K_DATA = 2'd0, K_FERR = 2'd1, K_PERR = 2'd2, K_OVR = 2'd3;

  typedef struct packed {
    logic       inst;
    logic [1:0] kind;
    logic [7:0] val;
  } exp_t;

  logic       sclk, nrst;
  logic [1:0] rxl, ready, valid_o, ferr_o, perr_o, ovr_o, busy_o;
  logic [7:0] data_o [2];

  exp_t sb[$];
  int   checks, failures;

  uart_ch340_rx_core #(.PARITY(0)) dut0 (
    .sclk(sclk), .nrst(nrst), .rx(rxl[0]), .rx_ready(ready[0]),
    .rx_data(data_o[0]), .rx_valid(valid_o[0]), .frame_err(ferr_o[0]),
    .parity_err(perr_o[0]), .overrun(ovr_o[0]), .busy(busy_o[0])
  );

  uart_ch340_rx_core #(.PARITY(2)) dut1 (
    .sclk(sclk), .nrst(nrst), .rx(rxl[1]), .rx_ready(ready[1]),
    .rx_data(data_o[1]), .rx_valid(valid_o[1]), .frame_err(ferr_o[1]),
    .parity_err(perr_o[1]), .overrun(ovr_o[1]), .busy(busy_o[1])
  );

  initial sclk = 1'b0;
  always #10 sclk = ~sclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic inst, input logic [1:0] kind, input logic [7:0] val);
    exp_t e;
    e.inst = inst; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  task automatic got(input logic inst, input logic [1:0] kind, input logic [7:0] val);
    exp_t a, e;
    a.inst = inst; a.kind = kind; a.val = val;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected: got inst=%0d kind=%0d data=%02h required none", inst, kind, val);
    end else begin
      e = sb.pop_front();
      check("sb_event{inst,kind,data}", 32'(a), 32'(e));
    end
  endtask

  task automatic monitor_loop();
    logic [1:0] pv, pr;
    pv = 2'b00;
    pr = 2'b00;
    forever begin
      @(negedge sclk);
      if (nrst) begin
        for (int i = 0; i < 2; i++) begin
          if (valid_o[i] && (!pv[i] || pr[i])) got(i[0], K_DATA, data_o[i]);
          if (ferr_o[i]) got(i[0], K_FERR, 8'h00);
          if (perr_o[i]) got(i[0], K_PERR, 8'h00);
          if (ovr_o[i])  got(i[0], K_OVR, 8'h00);
        end
      end
      pv = valid_o;
      pr = ready;
    end
  endtask

  // Drive one line level for n clocks; starts and ends 1 time unit after a rising edge.
  task automatic drive_bit(input int which, input logic v, input int n);
    rxl[which] = v;
    repeat (n) @(posedge sclk);
    #1;
  endtask

  // par_mode < 0: no parity bit, otherwise bit 0 of par_mode is sent as the parity bit.
  task automatic send_frame(input int which, input logic [7:0] b, input int par_mode, input logic stop_v);
    drive_bit(which, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(which, b[i], CPB);
    if (par_mode >= 0) drive_bit(which, par_mode[0], CPB);
    drive_bit(which, stop_v, CPB);
  endtask

  initial begin
    int fall_t;
    checks = 0;
    failures = 0;
    rxl = 2'b11;
    ready = 2'b01;
    nrst = 1'b0;
    fork
      monitor_loop();
    join_none
    repeat (5) @(posedge sclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_rx_data", 32'(data_o[i]), 32'h00);
      check("reset_flags{valid,ferr,perr,ovr,busy}",
            32'({valid_o[i], ferr_o[i], perr_o[i], ovr_o[i], busy_o[i]}), 32'h0);
    end
    nrst = 1'b1;
    drive_bit(0, 1'b1, 20);

    // Two bytes accepted immediately
    push(1'b0, K_DATA, 8'h55); send_frame(0, 8'h55, -1, 1'b1);
    push(1'b0, K_DATA, 8'hA5); send_frame(0, 8'hA5, -1, 1'b1);
    drive_bit(0, 1'b1, 50);

    // Back-to-back with consumer stalled: second byte overruns
    ready[0] = 1'b0;
    push(1'b0, K_DATA, 8'h3C); push(1'b0, K_OVR, 8'h00);
    send_frame(0, 8'h3C, -1, 1'b1);
    send_frame(0, 8'hC3, -1, 1'b1);
    check("held_valid", 32'(valid_o[0]), 32'd1);
    check("held_data", 32'(data_o[0]), 32'h3C);
    ready[0] = 1'b1;
    @(posedge sclk); #1;
    ready[0] = 1'b0;
    check("valid_after_accept", 32'(valid_o[0]), 32'd0);
    ready[0] = 1'b1;
    drive_bit(0, 1'b1, 50);

    // 100-clock glitch: START aborted at the mid-bit decision
    fall_t = 0;
    rxl[0] = 1'b0;
    for (int t = 1; t <= 400; t++) begin
      @(posedge sclk); #1;
      if (t == 50) check("glitch_busy_high", 32'(busy_o[0]), 32'd1);
      if (t == 100) rxl[0] = 1'b1;
      if (t > 100 && !busy_o[0]) begin
        fall_t = t;
        break;
      end
    end
    check("glitch_busy_fall_in_window", 32'(fall_t >= 215 && fall_t <= 230), 32'd1);
    drive_bit(0, 1'b1, 50);
    push(1'b0, K_DATA, 8'h81); send_frame(0, 8'h81, -1, 1'b1);

    // Stop bit 0 followed by a long break: exactly one frame error
    push(1'b0, K_FERR, 8'h00);
    send_frame(0, 8'h7E, -1, 1'b0);
    drive_bit(0, 1'b0, 5000);
    drive_bit(0, 1'b1, 100);
    push(1'b0, K_DATA, 8'h12); send_frame(0, 8'h12, -1, 1'b1);

    // Even parity receiver, consumer stalled
    push(1'b1, K_DATA, 8'h07); send_frame(1, 8'h07, 1, 1'b1);
    push(1'b1, K_PERR, 8'h00); send_frame(1, 8'h07, 0, 1'b1);
    check("par_valid_kept", 32'(valid_o[1]), 32'd1);
    check("par_data_kept", 32'(data_o[1]), 32'h07);
    drive_bit(1, 1'b1, 50);

    // Reset in the middle of data bit 3 of 0xF0
    ready[0] = 1'b0;
    push(1'b0, K_DATA, 8'h42); send_frame(0, 8'h42, -1, 1'b1);
    drive_bit(0, 1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b0, CPB);
    drive_bit(0, 1'b0, 200);
    check("pre_reset_busy", 32'(busy_o[0]), 32'd1);
    check("pre_reset_valid", 32'(valid_o[0]), 32'd1);
    nrst = 1'b0;
    #1;
    check("async_reset_rx_data", 32'(data_o[0]), 32'h00);
    check("async_reset_flags{valid,ferr,perr,ovr,busy}",
          32'({valid_o[0], ferr_o[0], perr_o[0], ovr_o[0], busy_o[0]}), 32'h0);
    drive_bit(0, 1'b0, 233);
    drive_bit(0, 1'b1, 100);
    nrst = 1'b1;
    drive_bit(0, 1'b1, CPB - 100 + 4 * CPB);
    ready[0] = 1'b1;
    push(1'b0, K_DATA, 8'h99); send_frame(0, 8'h99, -1, 1'b1);

    drive_bit(0, 1'b1, 500);
    check("sb_all_events_seen", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
